seq_restoring_divider: RTL and testbench



---
 rtl/arith_pkg.sv | 13 +
 rtl/trial_sub.sv | 29 ++
 rtl/seq_restoring_divider.sv | 126 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared constants and state encoding for the arithmetic comparison suite.
package arith_pkg;

   localparam int DIVIDEND_W = 8;
   localparam int DIVISOR_W  = 4;
   localparam int CNT_W      = $clog2(DIVIDEND_W + 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/trial_sub.sv
// Ripple subtractor a - b built as a + ~b + 1 through a chain of full-adder cells.
// borrow is the inverted carry out of the top cell.
module trial_sub #(
   parameter int W = 5
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         borrow
);

   logic [W-1:0] nb;
   logic         cy;

   assign nb = ~b;

   // Walk the full-adder cells LSB first, carry-in of 1 completes the two's complement.
   always_comb begin
      diff = '0;
      cy   = 1'b1;
      for (int i = 0; i < W; i++) begin
         diff[i] = a[i] ^ nb[i] ^ cy;
         cy      = (a[i] & nb[i]) | (a[i] & cy) | (nb[i] & cy);
      end
   end

   assign borrow = ~cy;

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one shift/subtract iteration per clock,
// results and done registered on the last iteration. A zero divisor skips
// RUN and reports all-ones quotient one cycle after acceptance.
module seq_restoring_divider
   import arith_pkg::*;
#(
   parameter int DIVIDEND_W = arith_pkg::DIVIDEND_W,
   parameter int DIVISOR_W  = arith_pkg::DIVISOR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero
);

   localparam int CW = $clog2(DIVIDEND_W + 1);
   localparam int PW = DIVISOR_W + 1;   // partial remainder carries one guard bit

   state_t                state, nxt;
   logic [CW-1:0]         cnt;
   logic [PW-1:0]         prem;
   logic [DIVIDEND_W-1:0] qreg;
   logic [DIVISOR_W-1:0]  dvs;
   logic                  dz_pend;

   logic [PW-1:0]         shifted, diff, new_prem;
   logic [DIVIDEND_W-1:0] new_q;
   logic                  borrow;
   logic                  last_iter;
   logic                  unused_prem_msb;

   // The guard bit is only ever produced by the trial, never shifted further.
   assign unused_prem_msb = prem[PW-1];

   assign shifted   = {prem[DIVISOR_W-1:0], qreg[DIVIDEND_W-1]};
   assign last_iter = (cnt == CW'(DIVIDEND_W - 1));

   trial_sub #(.W(PW)) u_trial (
      .a      (shifted),
      .b      ({1'b0, dvs}),
      .diff   (diff),
      .borrow (borrow)
   );

   // Restore on borrow: keep the shifted remainder and shift a 0 into the quotient.
   always_comb begin
      new_prem = borrow ? shifted : diff;
      new_q    = {qreg[DIVIDEND_W-2:0], ~borrow};
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   // Next state: a zero divisor never enters RUN.
   always_comb begin
      nxt = state;
      case (state)
         IDLE: if (start && (divisor != '0)) nxt = RUN;
         RUN:  if (last_iter)                nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Datapath, counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         prem        <= '0;
         qreg        <= '0;
         dvs         <= '0;
         dz_pend     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done    <= 1'b0;
         dz_pend <= 1'b0;
         if (dz_pend) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     dz_pend <= 1'b1;
                  end else begin
                     dvs  <= divisor;
                     prem <= '0;
                     qreg <= dividend;
                     cnt  <= '0;
                     busy <= 1'b1;
                  end
               end
            end
            RUN: begin
               prem <= new_prem;
               qreg <= new_q;
               cnt  <= cnt + CW'(1);
               if (last_iter) begin
                  quotient    <= new_q;
                  remainder   <= new_prem[DIVISOR_W-1:0];
                  div_by_zero <= 1'b0;
                  done        <= 1'b1;
                  busy        <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: vector table, hand-written
// corner sequences, exhaustive round-trip and random operands vs. a model.
module tb_seq_restoring_divider;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] dividend = '0;
   logic [3:0] divisor = '0;
   logic       busy, done, div_by_zero;
   logic [7:0] quotient;
   logic [3:0] remainder;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] a;
      logic [3:0] b;
      logic [7:0] q;
      logic [3:0] r;
      logic       dz;
      int         lat;
   } vec_t;

   vec_t vecs[8];

   seq_restoring_divider dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Issue one division from #1 after an edge with busy low; return at #1 after done.
   task automatic div_op(input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] eq, input logic [3:0] er,
                         input logic ed, input int elat, input string tag);
      int  lat;
      logic busy_seen;
      start = 1'b1; dividend = a; divisor = b;
      @(posedge clk); #1;
      start = 1'b0; dividend = 8'($urandom); divisor = 4'($urandom);
      busy_seen = busy;
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (done) begin lat = c; break; end
         busy_seen = busy_seen | busy;
      end
      check({tag, " latency"}, lat, elat);
      check({tag, " quotient"}, quotient, eq);
      check({tag, " remainder"}, remainder, er);
      check({tag, " div_by_zero"}, div_by_zero, ed);
      check({tag, " busy during op"}, busy_seen, (b != 0));
      check({tag, " busy at done"}, busy, 1'b0);
   endtask

   initial begin
      logic [7:0] ra;
      logic [3:0] rb;
      int lat;

      vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 8};
      vecs[1] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 8};
      vecs[2] = '{8'd5,   4'd9,  8'd0,   4'd5, 1'b0, 8};
      vecs[3] = '{8'd15,  4'd0,  8'hFF,  4'd0, 1'b1, 1};
      vecs[4] = '{8'd0,   4'd1,  8'd0,   4'd0, 1'b0, 8};
      vecs[5] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 8};
      vecs[6] = '{8'd1,   4'd15, 8'd0,   4'd1, 1'b0, 8};
      vecs[7] = '{8'd0,   4'd0,  8'hFF,  4'd0, 1'b1, 1};

      // Reset state
      #3 rst = 1'b1;
      #1;
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset quotient", quotient, 8'h00);
      check("reset remainder", remainder, 4'h0);
      check("reset div_by_zero", div_by_zero, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Table vectors
      for (int i = 0; i < 8; i++) begin
         div_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat, "vec");
         @(posedge clk); #1;
      end

      // Divide-by-zero results hold while idle
      div_op(8'd15, 4'd0, 8'hFF, 4'd0, 1'b1, 1, "dz");
      repeat (3) @(posedge clk); #1;
      check("dz hold quotient", quotient, 8'hFF);
      check("dz hold flag", div_by_zero, 1'b1);
      check("dz done cleared", done, 1'b0);

      // Exhaustive round-trip, each start issued in the cycle done is high
      for (int a = 0; a < 16; a++)
         for (int b = 1; b < 16; b++)
            div_op(8'(a * b), 4'(b), 8'(a), 4'd0, 1'b0, 8, "roundtrip");

      // Random operands vs. plain arithmetic
      @(posedge clk); #1;
      for (int i = 0; i < 60; i++) begin
         ra = 8'($urandom);
         rb = (i % 10 == 0) ? 4'd0 : 4'($urandom);
         if (rb == 0) div_op(ra, rb, 8'hFF, 4'd0, 1'b1, 1, "random");
         else         div_op(ra, rb, ra / 8'(rb), 4'(ra % 8'(rb)), 1'b0, 8, "random");
      end
      @(posedge clk); #1;

      // start while busy is ignored
      start = 1'b1; dividend = 8'd100; divisor = 4'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 start = 1'b1; dividend = 8'd50; divisor = 4'd5;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      for (int c = 5; c <= 20; c++) begin
         @(posedge clk); #1;
         if (done) begin lat = c; break; end
      end
      check("ignore latency", lat, 8);
      check("ignore quotient", quotient, 8'd33);
      check("ignore remainder", remainder, 4'd1);
      repeat (10) begin
         @(posedge clk); #1;
         check("ignore no extra done", done, 1'b0);
      end

      // Reset mid-RUN discards the division
      start = 1'b1; dividend = 8'd200; divisor = 4'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst busy", busy, 1'b0);
      check("midrst done", done, 1'b0);
      check("midrst quotient", quotient, 8'h00);
      check("midrst remainder", remainder, 4'h0);
      check("midrst div_by_zero", div_by_zero, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      lat = 0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (done || busy) lat = c;
      end
      check("midrst no done after release", lat, 0);
      div_op(8'd9, 4'd2, 8'd4, 4'd1, 1'b0, 8, "after rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
